load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 15 +
 rtl/load_store_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Requester-side bus of the load/store unit: access request, status and load result.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, funct3, addr, wdata, input busy, done, err, rdata);
  modport slave  (input req, we, funct3, addr, wdata, output busy, done, err, rdata);
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word accesses to a word-wide memory,
// sub-word stores done as read-modify-write.
module load_store_unit (
  input  logic                 clk,
  input  logic                 rst,
  load_store_unit_if.slave     lsu,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_nxt;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, old_q;
  logic        illegal, accept;
  logic [31:0] ld_sh, ld_val, st_rep;
  logic [NUM_LANES-1:0] lane_sel;

  assign accept = (state == IDLE) && lsu.req;

  // Codes 100/101 exist only as loads; anything else outside 000..010 is illegal.
  always_comb begin
    illegal = 1'b0;
    case (lsu.funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = lsu.addr[0];
      3'b010:  illegal = |lsu.addr[1:0];
      3'b100:  illegal = lsu.we;
      3'b101:  illegal = lsu.we | lsu.addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    case (state)
      IDLE: if (lsu.req) begin
        if (illegal)                    state_nxt = DONE;
        else if (!lsu.we)               state_nxt = RD;
        else if (lsu.funct3 == 3'b010)  state_nxt = WR;
        else                            state_nxt = RD;
      end
      RD: begin
        MemRead   = !rst;
        state_nxt = we_q ? WR : DONE;
      end
      WR: begin
        MemWrite  = !rst;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign lsu.busy = (state != IDLE);
  assign lsu.done = (state == DONE);

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= lsu.we;
      f3_q    <= lsu.funct3;
      addr_q  <= lsu.addr;
      wdata_q <= lsu.wdata;
    end
    if (state == RD && we_q) old_q <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu.err   <= 1'b0;
      lsu.rdata <= '0;
    end else begin
      if (accept) lsu.err <= illegal;
      if (state == RD && !we_q) lsu.rdata <= ld_val;
    end
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign ld_sh = mem_rdata >> {addr_q[1:0], 3'b000};
  always_comb begin
    case (f3_q)
      3'b000:  ld_val = {{24{ld_sh[7]}},  ld_sh[7:0]};
      3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_val = {24'h0, ld_sh[7:0]};
      3'b101:  ld_val = {16'h0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  // Store data replicated across all lanes so each byte lane just picks new vs old.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   st_rep = {4{wdata_q[7:0]}};
      2'b01:   st_rep = {2{wdata_q[15:0]}};
      default: st_rep = wdata_q;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    assign lane_sel[i] = (f3_q[1:0] == 2'b10)
                       | ((f3_q[1:0] == 2'b01) && (addr_q[1] == LN[1]))
                       | ((f3_q[1:0] == 2'b00) && (addr_q[1:0] == LN));
    assign mem_wdata[8*i +: 8] = lane_sel[i] ? st_rep[8*i +: 8] : old_q[8*i +: 8];
  end

  assign mem_addr = {addr_q[31:2], 2'b00};
endmodule
